// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Pattern bits, length and overlap mode are latched through a one-cycle config strobe.
module seq_detect_prog #(
    parameter int MAX_W = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_W-1:0] RST_PAT = 'b0000_1101,
    parameter int RST_LEN = 4,
    parameter logic RST_OVL = 1'b1,
    localparam int LEN_W = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [MAX_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int HW = MAX_W - 1;
    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(RST_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_W);

    logic [MAX_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    logic [MAX_W-1:0] window;
    logic [MAX_W-1:0] mask;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] cfg_len_c;

    // Bits above len_q-1 may hold stale history; the mask keeps them out of the compare.
    always_comb begin
        window = {hist_q, din};
        len_m1 = len_q - 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        y = en & ~cfg_load & (fill_q >= len_m1) & (((window ^ pat_q) & mask) == '0);
    end

    always_comb begin
        cfg_len_c = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_c = LEN_W'(1);
        end else if (cfg_len > MAX_LEN_C) begin
            cfg_len_c = MAX_LEN_C;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d  = cfg_pat;
            len_d  = cfg_len_c;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (en && y && !ovl_q) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[HW-1:0];
            fill_d = (fill_q >= len_m1) ? len_m1 : fill_q + 1'b1;
        end
        armed_d = (fill_d >= (len_d - 1'b1));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (y && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN_C;
            ovl_q   <= RST_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            armed_q <= (RST_LEN <= 1);
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign match_cnt = cnt_q;
    assign armed     = armed_q;

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Runtime-programmable serial pattern detector. It is the parametrised successor of the fixed "1101" Mealy detector. Pattern length (1..MAX_W), pattern bits and overlap mode are loaded through a config strobe. The block keeps a saturating match counter and sits on the same single-bit serial input path, one bit per clock.

Parameters:
MAX_W, 8, maximum pattern length in bits (2..16).
CNT_W, 8, width of the saturating match counter.
RST_PAT, 8'b0000_1101, pattern loaded at reset, LSB-aligned, newest bit at [0].
RST_LEN, 4, pattern length loaded at reset.
RST_OVL, 1, overlap mode loaded at reset (1 = overlapping).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  sample enable; din is consumed only when en=1.
din  in  1  serial data bit.
cfg_load  in  1  one-cycle strobe; latches cfg_pat, cfg_len and cfg_ovl.
cfg_pat  in  MAX_W  pattern; bit [len-1] is the first bit to arrive, bit [0] the last.
cfg_len  in  $clog2(MAX_W+1)  pattern length.
cfg_ovl  in  1  1 = overlapping matches allowed; 0 = history is flushed after each match.
cnt_clr  in  1  synchronous clear of match_cnt.
y  out  1  Mealy match pulse, combinational from din and state.
match_cnt  out  CNT_W  saturating count of matches.
armed  out  1  registered; 1 when fill >= len-1, i.e. the next bit can complete a match.

Behaviour:
- Reset (rst=0, async):
  - pat_q=RST_PAT, len_q=RST_LEN, ovl_q=RST_OVL.
  - hist=0, fill=0, match_cnt=0.
  - armed=0 (armed=1 if RST_LEN=1); y=0.
- State:
  - hist is MAX_W-1 bits; the newest bit is at [0].
  - fill is a count of valid history bits, saturating at len_q-1.
- Length clamp, applied on load: cfg_len=0 is stored as 1; cfg_len>MAX_W is stored as MAX_W.
- Match (combinational):
  - y = en & ~cfg_load & (fill >= len_q-1) & ({hist[len_q-2:0], din} == pat_q[len_q-1:0]).
  - For len_q=1: y = en & ~cfg_load & (din == pat_q[0]).
  - y asserts in the same cycle the final bit is present, i.e. zero latency.
- Clock edge, in priority order:
  1. cfg_load=1: latch the config, hist=0, fill=0. din is ignored that cycle, even if en=1.
  2. en=1 & y=1 & ovl_q=0: hist=0, fill=0 (the matched bits are consumed).
  3. en=1 (all other cases): hist = {hist[MAX_W-3:0], din}; fill = min(fill+1, len_q-1).
  4. en=0: hist and fill hold.
- Counter:
  - cnt_clr=1: match_cnt=0. cnt_clr wins over a simultaneous match, which is not counted.
  - Otherwise y=1 increments match_cnt, saturating at 2^CNT_W-1; it never wraps.
  - cfg_load does not clear match_cnt.
- armed is registered from the next-state fill: armed = (fill_next >= len_next-1).
- Reset mid-stream: all state returns to reset values immediately, with no clock edge needed. The first bit after release starts with empty history.
- Defaults reproduce the legacy 1101 overlapping detector cycle-for-cycle.

Test Plan:
1. Defaults, en=1, stream 11011011101 (MSB first, indices 0..10) -> y=1 at indices 3, 6 and 10 only; match_cnt=3.
2. cfg_load with cfg_pat=1101, cfg_len=4, cfg_ovl=0, then the same stream -> y=1 at indices 3 and 10 only; match_cnt increases by 2.
3. cfg_load with cfg_len=1, cfg_pat[0]=1, stream 10110 -> y=1 at indices 0, 2 and 3; armed=1 throughout. A separate load with cfg_len=0 -> behaves as length 1.
4. Default pattern, stream 110 with en=0 for 3 cycles (din toggling) and then en=1, din=1 -> y=1 on that cycle. Separately, drive rst=0 between clock edges after 110 -> hist=0, match_cnt=0 and armed=0 immediately; a following 1 gives no match.
5. Instance with CNT_W=2, stream 1101 repeated 5 times with overlap -> match_cnt reads 1, 2, 3, 3, 3 (saturates). cnt_clr in the same cycle as a match -> match_cnt=0.
6. cfg_load asserted on the cycle a final 1 of 1101 arrives -> y=0 and no count. The next cycles start with fill=0, so a full new pattern is needed before the next match.
